// File: rtl/clock_pkg.sv
// Shared types and constants for the board-clock PLL supervisor.
// Holds the lock FSM encoding, output bundle and default timing values.
package clock_pkg;

   localparam int unsigned CLK_HZ           = 25_000_000;
   localparam int unsigned LOCK_TIMEOUT_25M = CLK_HZ / 10;  // 100 ms of board clock
   localparam int unsigned LOSS_W           = 8;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAIL
   } lock_state_t;

   typedef struct packed {
      logic pll_rst;
      logic sys_rst;
      logic ready;
      logic fail;
   } ctrl_out_t;

   // Output bundle is a pure function of the FSM state.
   function automatic ctrl_out_t decode_outputs(lock_state_t s);
      ctrl_out_t o;
      o.pll_rst = (s == RESET_PLL) || (s == FAIL);
      o.sys_rst = (s != RUN);
      o.ready   = (s == RUN);
      o.fail    = (s == FAIL);
      return o;
   endfunction

   function automatic int unsigned max4(int unsigned a, int unsigned b,
                                        int unsigned c, int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// PLL control/status bundle between the lock supervisor and its surroundings.
// master is the supervisor side; slave is the PLL / downstream side.
interface pll_lock_ctrl_if;
   import clock_pkg::*;

   logic              pll_locked;
   logic              pll_rst;
   logic              sys_rst;
   logic              ready;
   logic              fail;
   logic [LOSS_W-1:0] loss_cnt;

   modport master (
      input  pll_locked,
      output pll_rst,
      output sys_rst,
      output ready,
      output fail,
      output loss_cnt
   );

   modport slave (
      output pll_locked,
      input  pll_rst,
      input  sys_rst,
      input  ready,
      input  fail,
      input  loss_cnt
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchroniser with synchronous reset to 0.
// Reusable for any asynchronous lock/status bit entering a clock domain.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL lock supervisor: pulses PLL reset, waits for a stable lock, releases
// the downstream reset and retries or gives up on repeated lock timeouts.
module pll_lock_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = 8,
   parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_25M,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned RETRY_LIMIT   = 3
) (
   input  logic            clk_25m,
   input  logic            rst,
   pll_lock_ctrl_if.master ctrl_if
);

   localparam int unsigned CNT_MAX = max4(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, RETRY_LIMIT);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam int unsigned RETRY_W = $clog2(RETRY_LIMIT + 1);

   if (RST_CYCLES < 4) begin : g_chk_rst
      $error("RST_CYCLES must be >= 4");
   end
   if (LOCK_TIMEOUT < 1) begin : g_chk_timeout
      $error("LOCK_TIMEOUT must be >= 1");
   end
   if (STABLE_CYCLES < 1) begin : g_chk_stable
      $error("STABLE_CYCLES must be >= 1");
   end
   if (RETRY_LIMIT < 1) begin : g_chk_retry
      $error("RETRY_LIMIT must be >= 1");
   end

   logic              lock_s;
   lock_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [LOSS_W-1:0] loss_q, loss_d;
   ctrl_out_t         out_q;

   sync_2ff u_lock_sync (
      .clk_i (clk_25m),
      .rst_i (rst),
      .d_i   (ctrl_if.pll_locked),
      .q_o   (lock_s)
   );

   // Next-state logic; cnt clears on every transition.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      retry_d = retry_q;
      loss_d  = loss_q;
      unique case (state_q)
         RESET_PLL: begin
            if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         WAIT_LOCK: begin
            // A lock seen on the timeout cycle takes priority over the retry.
            if (lock_s) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
               retry_d = retry_q + RETRY_W'(1);
               state_d = (retry_d == RETRY_W'(RETRY_LIMIT)) ? FAIL : RESET_PLL;
               cnt_d   = '0;
            end
         end
         STABLE: begin
            if (!lock_s) begin
               state_d = RESET_PLL;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
               state_d = RUN;
               retry_d = '0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            cnt_d = '0;
            if (!lock_s) begin
               state_d = RESET_PLL;
               loss_d  = (loss_q == '1) ? loss_q : loss_q + LOSS_W'(1);
            end
         end
         FAIL: begin
            cnt_d = '0;
         end
         default: begin
            state_d = RESET_PLL;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered alongside the state they decode.
   always_ff @(posedge clk_25m) begin
      if (rst) begin
         state_q <= RESET_PLL;
         cnt_q   <= '0;
         retry_q <= '0;
         loss_q  <= '0;
         out_q   <= decode_outputs(RESET_PLL);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         loss_q  <= loss_d;
         out_q   <= decode_outputs(state_d);
      end
   end

   assign ctrl_if.pll_rst  = out_q.pll_rst;
   assign ctrl_if.sys_rst  = out_q.sys_rst;
   assign ctrl_if.ready    = out_q.ready;
   assign ctrl_if.fail     = out_q.fail;
   assign ctrl_if.loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl: a phase/timestamp reference model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_pll_lock_ctrl;

   localparam int unsigned RC = 4;
   localparam int unsigned LT = 20;
   localparam int unsigned SC = 8;
   localparam int unsigned RL = 2;

   logic clk_25m = 1'b0;
   logic rst     = 1'b1;

   always #20 clk_25m = ~clk_25m;

   pll_lock_ctrl_if bus ();

   pll_lock_ctrl #(
      .RST_CYCLES    (RC),
      .LOCK_TIMEOUT  (LT),
      .STABLE_CYCLES (SC),
      .RETRY_LIMIT   (RL)
   ) dut (
      .clk_25m (clk_25m),
      .rst     (rst),
      .ctrl_if (bus)
   );

   typedef struct {
      bit pll_rst;
      bit sys_rst;
      bit ready;
      bit fail;
      int loss;
   } exp_t;

   typedef enum {P_RST, P_WAIT, P_STAB, P_RUN, P_FAIL} phase_e;

   exp_t   exp_q[$];
   int     n_checks = 0;
   int     n_err    = 0;

   phase_e ph       = P_RST;
   longint edge_no  = 0;
   longint start    = 0;
   int     retries  = 0;
   int     losses   = 0;
   bit     dl[$];

   task automatic chk(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void enter(phase_e p);
      ph    = p;
      start = edge_no + 1;
   endfunction

   // Reference: lock seen by the FSM is the input two edges back; each phase
   // lasts a fixed number of edges measured from its start timestamp.
   function automatic void model_edge(bit r, bit l);
      bit     ls;
      longint len;
      exp_t   e;
      edge_no++;
      if (r) begin
         ph      = P_RST;
         start   = edge_no + 1;
         retries = 0;
         losses  = 0;
         dl      = '{1'b0, 1'b0};
      end else begin
         ls  = dl.pop_front();
         dl.push_back(l);
         len = edge_no - start + 1;
         case (ph)
            P_RST:  if (len >= RC) enter(P_WAIT);
            P_WAIT: begin
               if (ls) enter(P_STAB);
               else if (len >= LT) begin
                  retries++;
                  enter((retries >= RL) ? P_FAIL : P_RST);
               end
            end
            P_STAB: begin
               if (!ls) enter(P_RST);
               else if (len >= SC) begin
                  retries = 0;
                  enter(P_RUN);
               end
            end
            P_RUN: begin
               if (!ls) begin
                  if (losses < 255) losses++;
                  enter(P_RST);
               end
            end
            default: ;
         endcase
      end
      e.pll_rst = (ph == P_RST) || (ph == P_FAIL);
      e.sys_rst = (ph != P_RUN);
      e.ready   = (ph == P_RUN);
      e.fail    = (ph == P_FAIL);
      e.loss    = losses;
      exp_q.push_back(e);
   endfunction

   task automatic cyc(bit r, bit l);
      rst            = r;
      bus.pll_locked = l;
      model_edge(r, l);
      @(posedge clk_25m);
      #1;
   endtask

   always @(negedge clk_25m) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("outputs{pll_rst,sys_rst,ready,fail,loss}",
             int'({bus.pll_rst, bus.sys_rst, bus.ready, bus.fail, bus.loss_cnt}),
             int'({e.pll_rst, e.sys_rst, e.ready, e.fail, 8'(e.loss)}));
      end
   end

   initial begin
      bus.pll_locked = 1'b0;

      // Clean start with lock held high.
      repeat (3) cyc(1'b1, 1'b1);
      chk("reset_pll_rst", int'(bus.pll_rst), 1);
      chk("reset_ready", int'(bus.ready), 0);
      for (int i = 1; i <= 13; i++) begin
         cyc(1'b0, 1'b1);
         if (i == 3)  chk("start_pll_rst_hi", int'(bus.pll_rst), 1);
         if (i == 4)  chk("start_pll_rst_lo", int'(bus.pll_rst), 0);
         if (i == 12) chk("start_ready_early", int'(bus.ready), 0);
         if (i == 13) begin
            chk("start_ready", int'(bus.ready), 1);
            chk("start_sys_rst", int'(bus.sys_rst), 0);
         end
      end
      repeat (5) cyc(1'b0, 1'b1);

      // Single-cycle lock loss in RUN.
      cyc(1'b0, 1'b0);
      for (int j = 1; j <= 16; j++) begin
         cyc(1'b0, 1'b1);
         if (j == 1) chk("loss_sys_rst_t2", int'(bus.sys_rst), 0);
         if (j == 2) begin
            chk("loss_sys_rst_t3", int'(bus.sys_rst), 1);
            chk("loss_pll_rst_t3", int'(bus.pll_rst), 1);
            chk("loss_cnt_1", int'(bus.loss_cnt), 1);
         end
         if (j == 14) chk("loss_ready_early", int'(bus.ready), 0);
         if (j == 15) chk("loss_ready", int'(bus.ready), 1);
      end

      // Glitch while in STABLE: no loss counted, still reaches RUN.
      repeat (2) cyc(1'b1, 1'b1);
      repeat (7) cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      repeat (25) cyc(1'b0, 1'b1);
      chk("glitch_loss_cnt", int'(bus.loss_cnt), 0);
      chk("glitch_ready", int'(bus.ready), 1);

      // Randomised lock behaviour with occasional resets.
      for (int k = 0; k < 800; k++)
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 11) != 0));

      // Repeated timeouts lead to FAIL, which ignores lock until rst.
      repeat (2) cyc(1'b1, 1'b0);
      for (int n = 1; n <= 60; n++) begin
         cyc(1'b0, 1'b0);
         if (n == 47) chk("timeout_fail_early", int'(bus.fail), 0);
         if (n == 48) chk("timeout_fail", int'(bus.fail), 1);
      end
      repeat (20) cyc(1'b0, 1'b1);
      chk("fail_held", int'(bus.fail), 1);
      chk("fail_pll_rst", int'(bus.pll_rst), 1);
      chk("fail_ready", int'(bus.ready), 0);

      // Mid-operation reset from RUN with three recorded losses.
      repeat (2) cyc(1'b1, 1'b1);
      repeat (20) cyc(1'b0, 1'b1);
      repeat (3) begin
         cyc(1'b0, 1'b0);
         repeat (18) cyc(1'b0, 1'b1);
      end
      chk("mid_loss_cnt_3", int'(bus.loss_cnt), 3);
      cyc(1'b1, 1'b1);
      chk("mid_ready", int'(bus.ready), 0);
      chk("mid_sys_rst", int'(bus.sys_rst), 1);
      chk("mid_pll_rst", int'(bus.pll_rst), 1);
      chk("mid_loss_cnt_0", int'(bus.loss_cnt), 0);
      for (int i = 1; i <= 13; i++) begin
         cyc(1'b0, 1'b1);
         if (i == 12) chk("mid_restart_early", int'(bus.ready), 0);
         if (i == 13) chk("mid_restart_ready", int'(bus.ready), 1);
      end

      // Loss counter saturation.
      repeat (260) begin
         cyc(1'b0, 1'b0);
         repeat (18) cyc(1'b0, 1'b1);
      end
      chk("sat_loss_cnt", int'(bus.loss_cnt), 255);

      // One timeout, then lock arriving on the final WAIT_LOCK cycle.
      repeat (2) cyc(1'b1, 1'b0);
      repeat (45) cyc(1'b0, 1'b0);
      for (int n = 1; n <= 20; n++) begin
         cyc(1'b0, 1'b1);
         if (n == 3) begin
            chk("race_no_fail", int'(bus.fail), 0);
            chk("race_stable_pll_rst", int'(bus.pll_rst), 0);
         end
      end
      chk("race_ready", int'(bus.ready), 1);

      repeat (2) @(negedge clk_25m);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/pll_lock_ctrl.md
Name: pll_lock_ctrl

Overview:
- Single-clock supervisor for the TMDS PLL's control end. Runs on the free-running board clock.
- Drives the PLL reset input and watches the PLL's raw, unsynchronised lock output.
- Waits for lock to stay stable before releasing a downstream reset; on lock loss it re-resets the PLL.
- Flags a permanent failure after repeated lock timeouts. Sits between the board clock pin and the clock generator; its outputs gate reset of the pixel-domain logic.

Parameters:
- RST_CYCLES, 8, cycles pll_rst is held high per reset attempt; must be >= 4 (elaboration-time check).
- LOCK_TIMEOUT, 2500000, cycles to wait for lock after pll_rst is released (100 ms at 25 MHz); must be >= 1.
- STABLE_CYCLES, 1024, consecutive cycles of synchronised lock required before release; must be >= 1.
- RETRY_LIMIT, 3, consecutive lock timeouts before entering FAIL; must be >= 1.

Ports:
- clk_25m, in, 1, board clock (25 MHz, free-running, independent of the PLL).
- rst, in, 1, synchronous active-high reset.
- pll_locked, in, 1, raw PLL lock, asynchronous to clk_25m.
- pll_rst, out, 1, reset to PLL, active-high.
- sys_rst, out, 1, downstream reset, active-high; low only in RUN.
- ready, out, 1, high only in RUN.
- fail, out, 1, high only in FAIL.
- loss_cnt, out, 8, count of lock losses seen in RUN; saturates at 255.

Behaviour:
- Reset values: pll_locked passes through a 2-flop synchroniser; both flops reset to 0, giving lock_s with 2-cycle latency.
- Under rst, the module resets:
  - state=RESET_PLL, cnt=0, retry=0, loss_cnt=0;
  - pll_rst=1, sys_rst=1, ready=0, fail=0.
- Output decode: all outputs are a pure decode of registered state (plus the loss_cnt register). There is no combinational path from any input to any output.
  - pll_rst=1 in RESET_PLL and FAIL.
  - sys_rst=0 and ready=1 only in RUN.
  - fail=1 only in FAIL.
- cnt is a single shared counter, width $clog2 of the largest parameter. It clears on every state transition.
- RESET_PLL: lock_s is ignored. When cnt==RST_CYCLES-1, go to WAIT_LOCK; otherwise cnt++. pll_rst is therefore high for exactly RST_CYCLES cycles after rst deasserts.
- WAIT_LOCK:
  - lock_s=1: go to STABLE.
  - Otherwise, when cnt==LOCK_TIMEOUT-1: retry++. If the new retry==RETRY_LIMIT, go to FAIL; otherwise go to RESET_PLL.
  - Otherwise cnt++.
  - If lock arrives on the timeout cycle itself, lock wins and no retry is counted.
- STABLE:
  - lock_s=0: go to RESET_PLL. This is a lock glitch; retry is unchanged and loss_cnt is unchanged.
  - Otherwise, when cnt==STABLE_CYCLES-1: go to RUN, and clear retry to 0.
  - Otherwise cnt++.
- RUN:
  - lock_s=0: go to RESET_PLL and increment loss_cnt (saturating at 255).
  - Timing: with a lock drop on pll_locked at edge t, state is RESET_PLL and sys_rst=1 from edge t+3.
- FAIL: terminal state with pll_rst held high. Only rst exits it.
- Startup latency with pll_locked constantly 1: ready rises RST_CYCLES+1+STABLE_CYCLES cycles after the first edge with rst low.
- rst mid-operation, from any state: the next edge forces the reset values, including loss_cnt=0 and the synchroniser flops.
- Retry width is $clog2(RETRY_LIMIT+1).

Decomposition:
- Shared package clock_pkg holds:
  - the state enum lock_state_t {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL};
  - a localparam for the default lock timeout at 25 MHz.
- One natural sub-module: sync_2ff, a 2-flop single-bit synchroniser with synchronous reset to 0. It is reusable for other cross-domain lock and status bits.

Test Plan:
All tests use overrides RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, RETRY_LIMIT=2.
1. Clean start: pll_locked=1 constant, rst released -> pll_rst high for 4 cycles, then ready=1 and sys_rst=0 exactly 13 cycles after rst release; fail=0 throughout.
2. Lock loss in RUN: from RUN, drop pll_locked at edge t for 1 cycle -> sys_rst=1 and pll_rst=1 at edge t+3, loss_cnt=1, ready again 13 cycles after re-entry to RESET_PLL.
3. Glitch during STABLE: lock high, drop it 3 cycles into STABLE -> return to RESET_PLL, loss_cnt stays 0, retry unchanged, ready eventually asserts.
4. Timeouts to FAIL: pll_locked=0 forever -> two windows of 4 reset + 20 wait cycles, then fail=1 and pll_rst=1 held; raising pll_locked afterwards has no effect until rst.
5. Mid-operation reset: assert rst in RUN with loss_cnt=3 -> next edge gives ready=0, sys_rst=1, pll_rst=1, loss_cnt=0, and the clean-start sequence repeats.
6. Saturation and race: 260 RUN lock losses give loss_cnt=255. Separately, lock rising on exactly the 20th WAIT_LOCK cycle -> enters STABLE with retry not incremented.
